// File: rtl/sync_register_source_pkg.sv
// sync_register_source_pkg: shared state encoding and width constants for the register source front end
package sync_register_source_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_e;
    localparam int COAL_W = 16;
    localparam int HCNT_W = 8;
endpackage

// File: rtl/sync_register_source_if.sv
// sync_register_source_if: write port plus synchronizer handshake of the register source
// master: local write logic and synchronizer side (drives wEN/wBE/wD_IN/sRDY)
// slave : sync_register_source (drives sEN/sD_OUT/DIRTY)
// SYNC_REGISTER_SOURCE_COALESCE_COUNT_EN adds CNT_CLR (in) and COAL_CNT (out)
interface sync_register_source_if
    import sync_register_source_pkg::*;
#(
    parameter int width = 32
);
    logic                     wEN;
    logic [(width+7)/8-1:0]   wBE;
    logic [width-1:0]         wD_IN;
    logic                     sRDY;
    logic                     sEN;
    logic [width-1:0]         sD_OUT;
    logic                     DIRTY;
`ifdef SYNC_REGISTER_SOURCE_COALESCE_COUNT_EN
    logic                     CNT_CLR;
    logic [COAL_W-1:0]        COAL_CNT;
    modport master (output wEN, wBE, wD_IN, sRDY, CNT_CLR, input sEN, sD_OUT, DIRTY, COAL_CNT);
    modport slave  (input wEN, wBE, wD_IN, sRDY, CNT_CLR, output sEN, sD_OUT, DIRTY, COAL_CNT);
`else
    modport master (output wEN, wBE, wD_IN, sRDY, input sEN, sD_OUT, DIRTY);
    modport slave  (input wEN, wBE, wD_IN, sRDY, output sEN, sD_OUT, DIRTY);
`endif
endinterface

// File: rtl/sync_register_source_bemerge.sv
// sync_register_source_bemerge: byte-lane merge of write data into the shadow value
// sh_i: current shadow, be_i: lane enables, d_i: write data, q_o: merged value
module sync_register_source_bemerge #(
    parameter int width = 32
) (
    input  logic [width-1:0]       sh_i,
    input  logic [(width+7)/8-1:0] be_i,
    input  logic [width-1:0]       d_i,
    output logic [width-1:0]       q_o
);
    genvar b;
    for (b = 0; b < width; b++) begin : g_bit
        assign q_o[b] = be_i[b/8] ? d_i[b] : sh_i[b];
    end
endmodule

// File: rtl/sync_register_source.sv
// sync_register_source: coalescing shadow register feeding a handshake register synchronizer
// CLK/RST: source clock, synchronous active-high reset
// bus (slave): writes in, sEN/sD_OUT/DIRTY out, sRDY in
// SYNC_REGISTER_SOURCE_COALESCE_COUNT_EN enables the overwrite counter (CNT_CLR/COAL_CNT)
module sync_register_source
    import sync_register_source_pkg::*;
#(
    parameter int               width   = 32,
    parameter logic [width-1:0] init    = '0,
    parameter int               holdoff = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    sync_register_source_if.slave bus
);
    localparam logic [HCNT_W-1:0] HOLD_N = HCNT_W'(holdoff);
    state_e              state_q, state_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [width-1:0]    shadow_q, merged;
    logic                dirty_q, dirty_d;
    logic                eff, issue;
    sync_register_source_bemerge #(.width(width)) u_merge (
        .sh_i (shadow_q),
        .be_i (bus.wBE),
        .d_i  (bus.wD_IN),
        .q_o  (merged)
    );
    always_comb begin
        eff     = bus.wEN && |bus.wBE;
        issue   = state_q == PEND && bus.sRDY;
        // a write landing on the issue cycle keeps the shadow dirty
        dirty_d = eff || (dirty_q && !issue);
        state_d = state_q;
        hcnt_d  = hcnt_q;
        if (state_q == IDLE) begin
            state_d = eff ? PEND : IDLE;
        end else if (state_q == PEND) begin
            if (issue) begin
                state_d = HOLD_N != '0 ? HOLD : eff ? PEND : IDLE;
                hcnt_d  = HOLD_N;
            end
        end else begin
            // leaving on the count of 1 gives exactly holdoff idle cycles
            hcnt_d = hcnt_q - 1'b1;
            if (hcnt_q <= 1) state_d = dirty_d ? PEND : IDLE;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            shadow_q <= init;
            dirty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            shadow_q <= bus.wEN ? merged : shadow_q;
            dirty_q  <= dirty_d;
        end
    end
    assign bus.sEN    = issue;
    assign bus.sD_OUT = shadow_q;
    assign bus.DIRTY  = dirty_q;
`ifdef SYNC_REGISTER_SOURCE_COALESCE_COUNT_EN
    logic [COAL_W-1:0] coal_q, coal_d;
    // counts unsent values that were overwritten; saturates, clear wins
    always_comb
        coal_d = bus.CNT_CLR ? '0 :
                 (eff && dirty_q && !issue && coal_q != '1) ? coal_q + 1'b1 : coal_q;
    always_ff @(posedge CLK) begin
        if (RST) coal_q <= '0;
        else     coal_q <= coal_d;
    end
    assign bus.COAL_CNT = coal_q;
`endif
endmodule

// File: doc/sync_register_source.md
# sync_register_source

Source-domain front end for the handshake register synchronizer. Accepts byte-enabled register writes from local control logic at any rate, merges them into a shadow copy, and issues at most one transfer per synchronizer handshake (sEN only while sRDY is high), coalescing writes that arrive while a transfer is outstanding. Sits directly upstream of the clock-crossing register, in its sCLK domain; its sEN/sD_OUT drive that block's sEN/sD_IN and its sRDY input is that block's sRDY.

## Interface
- width, 32, data width in bits; byte-enable width is (width+7)/8
- init, all zeros, reset value of the shadow register (must equal the synchronizer's init)
- holdoff, 0, minimum idle cycles enforced after each issue before the next (0..255)
- CLK  input  1  source clock (the synchronizer's sCLK)
- RST  input  1  reset; synchronous to CLK and active-high
- wEN  input  1  write strobe
- wBE  input  (width+7)/8  byte enables for wEN; bit i covers data bits [8i+7:8i] (top lane partial if width%8≠0)
- wD_IN  input  width  write data
- sRDY  input  1  synchronizer ready
- sEN  output  1  transfer strobe to synchronizer
- sD_OUT  output  width  shadow value presented to synchronizer
- DIRTY  output  1  shadow holds a value not yet issued
- CNT_CLR  input  1  clears coalesce counter (present only with macro)
- COAL_CNT  output  16  coalesce counter (present only with macro)

## Operation
- Shadow register: on wEN, each enabled lane takes wD_IN; disabled lanes keep their value. wEN with wBE=0 is a no-op (no dirty set, no count).
- DIRTY set by any effective write; cleared on issue unless an effective write occurs in the same cycle (write wins, DIRTY stays 1).
- States: IDLE (DIRTY=0), PEND (DIRTY=1, waiting), HOLD (post-issue holdoff).
- IDLE -> PEND on effective write.
- PEND: sEN = sRDY (combinational); on sEN -> HOLD if holdoff>0, else stays PEND if same-cycle write, else IDLE.
- HOLD: loads counter with holdoff on entry, decrements each cycle; at 0 -> PEND if DIRTY else IDLE. Writes during HOLD update shadow and DIRTY only.
- sD_OUT is the shadow register output; the value issued is the pre-write shadow on a same-cycle write+issue; the write goes out on a later issue.
- sEN never asserted in IDLE or HOLD, never while sRDY=0.

## Timing
- Reset (RST high at CLK edge): shadow=init, sD_OUT=init, DIRTY=0, sEN=0, state IDLE, holdoff counter 0, COAL_CNT=0. RST mid-transfer discards pending data; synchronizer reset is separate.
- Write to sEN latency: 1 cycle minimum (write at edge n, sEN high during cycle n+1 if sRDY).
- sEN is high for exactly one cycle per issue, as the synchronizer drops sRDY the cycle after sEN. No sEN for sRDY-high cycles in HOLD.
- After issue with holdoff=H: next sEN no earlier than H+1 cycles later.

## Configuration
- SYNC_REGISTER_SOURCE_COALESCE_COUNT_EN defined: CNT_CLR/COAL_CNT ports and 16-bit counter exist. Counter increments by 1 on each effective write while DIRTY=1 and no issue that cycle, i.e. an unsent value overwritten. It saturates at 0xFFFF; CNT_CLR zeroes it, and CNT_CLR wins over same-cycle increment.
- Undefined: ports and counter absent; all other behaviour identical.

## Structure
- Shared package: state encoding (IDLE=2'd0, PEND=2'd1, HOLD=2'd2), COAL_CNT width constant (16), holdoff counter width (8).
- One sub-module natural: sync_register_source_bemerge (byte-lane merge of shadow, wBE, wD_IN; combinational, parameterised by width).

## Test plan
- Reset then sRDY=1, width=32: write 0xDEADBEEF wBE=4'hF -> sEN one cycle later, sD_OUT=0xDEADBEEF, DIRTY 1->0.
- sRDY=0, writes 0x11111111 wBE=4'hF then 0x000000AA wBE=4'h1 -> DIRTY=1, no sEN. sRDY raised -> single sEN with sD_OUT=0x111111AA, COAL_CNT=1 (macro on).
- Write coincident with issue cycle -> issued value is the old shadow; DIRTY stays 1; second sEN on next sRDY with the new value.
- holdoff=4, sRDY tied 1, continuous writes -> sEN spaced exactly 5 cycles apart.
- wEN with wBE=0 in IDLE -> no DIRTY, no sEN, COAL_CNT unchanged.
- 70000 overwrites with sRDY=0 -> COAL_CNT=0xFFFF (saturated). Assert CNT_CLR with a coincident write -> 0. Then assert RST while PEND -> DIRTY=0, sD_OUT=init, no sEN.
